// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Round-robin access scheduler sharing one single-ported 8x16 register array
//   between two requesters. The granted requester drives the array address,
//   write data and load enable for the duration of its grant cycle; reads are
//   captured into a per-requester data register at the end of the grant cycle.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     req/lock/we/addr/wdata  per-requester transaction inputs (suffix 0 / 1)
//     gnt0, gnt1              registered grant, transaction executes this cycle
//     rvalid0, rvalid1        one-cycle read data valid pulse
//     rdata0, rdata1          read data, held until that requester's next read
//     mem_addr/mem_in/mem_load  array control, zero while nobody is granted
//     mem_out                 array read data, combinational from mem_addr
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no grant, array inputs forced to zero
//   G0    | requester 0 owns the array this cycle
//   G1    | requester 1 owns the array this cycle
module ram_arbiter #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 3,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  wdata0,
  input  logic [WIDTH-1:0]  wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [WIDTH-1:0]  rdata0,
  output logic [WIDTH-1:0]  rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_in,
  output logic              mem_load,
  input  logic [WIDTH-1:0]  mem_out
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t           state;
  logic             ptr;
  logic [CNT_W-1:0] bcnt;
  logic [CNT_W-1:0] bcnt_inc;
  logic             keep0;
  logic             keep1;

  // Burst length saturates so a long uncontested lock never wraps the count.
  assign bcnt_inc = (bcnt == BURST_MAX) ? bcnt : bcnt + BURST_ONE;

  // Locked stay: the burst cap only bites while the other side is waiting.
  assign keep0 = lock0 & req0 & ((bcnt < BURST_MAX) | ~req1);
  assign keep1 = lock1 & req1 & ((bcnt < BURST_MAX) | ~req0);

  // Array inputs follow the grant combinationally, so a request dropped inside
  // its grant cycle (or an async reset) removes the load before the edge.
  always_comb begin
    mem_addr = '0;
    mem_in   = '0;
    mem_load = 1'b0;
    case (state)
      G0: begin
        mem_addr = addr0;
        mem_in   = wdata0;
        mem_load = req0 & we0;
      end
      G1: begin
        mem_addr = addr1;
        mem_in   = wdata1;
        mem_load = req1 & we1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      bcnt    <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          // ptr only matters when both are asking.
          if (req0 & (~req1 | ~ptr)) begin
            state <= G0;
            gnt0  <= 1'b1;
            bcnt  <= BURST_ONE;
          end else if (req1) begin
            state <= G1;
            gnt1  <= 1'b1;
            bcnt  <= BURST_ONE;
          end
        end
        G0: begin
          if (req0 & ~we0) begin
            rdata0  <= mem_out;
            rvalid0 <= 1'b1;
          end
          if (keep0) begin
            bcnt <= bcnt_inc;
          end else begin
            ptr <= 1'b1;
            if (req1) begin
              state <= G1;
              gnt0  <= 1'b0;
              gnt1  <= 1'b1;
              bcnt  <= BURST_ONE;
            end else if (req0) begin
              bcnt <= bcnt_inc;
            end else begin
              state <= IDLE;
              gnt0  <= 1'b0;
              bcnt  <= '0;
            end
          end
        end
        G1: begin
          if (req1 & ~we1) begin
            rdata1  <= mem_out;
            rvalid1 <= 1'b1;
          end
          if (keep1) begin
            bcnt <= bcnt_inc;
          end else begin
            ptr <= 1'b0;
            if (req0) begin
              state <= G0;
              gnt1  <= 1'b0;
              gnt0  <= 1'b1;
              bcnt  <= BURST_ONE;
            end else if (req1) begin
              bcnt <= bcnt_inc;
            end else begin
              state <= IDLE;
              gnt1  <= 1'b0;
              bcnt  <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          bcnt  <= '0;
        end
      endcase
    end
  end

endmodule
